// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction-fetch sequencer
module pc_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            inst_valid,
    input  logic            exec_done,
    input  logic [1:0]      PcSrc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign,
    output logic            halted
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'b100};

    state_t          state, state_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] target;
    logic            req_n;
    logic [31:0]     inst_n;
    logic            valid_n;
    logic            misalign_n;
    logic            halted_n;

    assign imem_addr = pc;
    assign pc_plus4  = pc + FOUR;

    // Next-PC candidate selected by the branch controller; jalr clears bit 0.
    always_comb begin
        target = pc_plus4;
        case (PcSrc)
            2'b00:   target = pc_plus4;
            2'b01:   target = pc + imm;
            2'b10:   target = {alu_result[XLEN-1:1], 1'b0};
            default: target = pc;
        endcase
    end

    // Next-state and next-output logic; every register holds unless its state says otherwise.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_n      = imem_req;
        inst_n     = inst;
        valid_n    = inst_valid;
        misalign_n = misalign;
        halted_n   = halted;
        case (state)
            BOOT: begin
                state_n = FETCH;
                req_n   = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    inst_n  = imem_rdata;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    if (ALIGN_CHECK && (target[1:0] != 2'b00)) begin
                        misalign_n = 1'b1;
                        halted_n   = 1'b1;
                        valid_n    = 1'b0;
                        req_n      = 1'b0;
                        state_n    = HALT;
                    end else begin
                        pc_n    = target;
                        valid_n = 1'b0;
                        req_n   = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            HALT: begin
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
            default: begin
                state_n = BOOT;
                req_n   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            inst       <= 32'd0;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_req   <= req_n;
            inst       <= inst_n;
            inst_valid <= valid_n;
            misalign   <= misalign_n;
            halted     <= halted_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_done;
    logic [1:0]  PcSrc;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic        halted;

    int passed = 0;
    int total  = 0;

    // reference state: the architectural PC the program should be at
    logic [31:0] mpc;
    logic [31:0] minst;
    logic        mhalt;

    pc_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .exec_done(exec_done), .PcSrc(PcSrc), .imm(imm), .alu_result(alu_result),
        .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".pc"},         pc,                 32'h0);
        chk({tag, ".req"},        {31'd0, imem_req},  32'd0);
        chk({tag, ".inst"},       inst,               32'h0);
        chk({tag, ".valid"},      {31'd0, inst_valid}, 32'd0);
        chk({tag, ".misalign"},   {31'd0, misalign},  32'd0);
        chk({tag, ".halted"},     {31'd0, halted},    32'd0);
        mpc   = 32'h0;
        mhalt = 1'b0;
    endtask

    // Fetch one instruction: entry with req already raised, stall ack_delay cycles, then ack.
    task automatic fetch_phase(input int ack_delay, input logic [31:0] word);
        chk("fetch.req", {31'd0, imem_req}, 32'd1);
        chk("fetch.addr", imem_addr, mpc);
        for (int i = 0; i < ack_delay; i++) begin
            imem_ack   = 1'b0;
            exec_done  = $urandom_range(0, 1);
            PcSrc      = 2'($urandom);
            imm        = $urandom;
            alu_result = $urandom;
            step();
            chk("stall.req", {31'd0, imem_req}, 32'd1);
            chk("stall.addr", imem_addr, mpc);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        minst      = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("ack.inst", inst, minst);
        chk("ack.valid", {31'd0, inst_valid}, 32'd1);
        chk("ack.req", {31'd0, imem_req}, 32'd0);
        chk("ack.plus4", pc_plus4, mpc + 32'd4);
    endtask

    // Execute the held instruction and commit the next PC (or trap).
    task automatic exec_phase(input int done_delay, input logic [1:0] src,
                              input logic [31:0] imm_v, input logic [31:0] alu_v);
        logic [31:0] nxt;
        for (int i = 0; i < done_delay; i++) begin
            exec_done  = 1'b0;
            imem_ack   = $urandom_range(0, 1);
            imem_rdata = $urandom;
            step();
            chk("exwait.inst", inst, minst);
            chk("exwait.valid", {31'd0, inst_valid}, 32'd1);
        end
        imem_ack   = 1'b0;
        case (src)
            2'b00:   nxt = mpc + 32'd4;
            2'b01:   nxt = mpc + imm_v;
            2'b10:   nxt = alu_v & 32'hFFFF_FFFE;
            default: nxt = mpc;
        endcase
        exec_done  = 1'b1;
        PcSrc      = src;
        imm        = imm_v;
        alu_result = alu_v;
        step();
        exec_done  = 1'b0;
        if (nxt[1:0] != 2'b00) begin
            mhalt = 1'b1;
            chk("trap.misalign", {31'd0, misalign}, 32'd1);
            chk("trap.halted", {31'd0, halted}, 32'd1);
            chk("trap.pc", pc, mpc);
            chk("trap.req", {31'd0, imem_req}, 32'd0);
        end else begin
            mpc = nxt;
            chk("commit.pc", pc, mpc);
            chk("commit.req", {31'd0, imem_req}, 32'd1);
            chk("commit.valid", {31'd0, inst_valid}, 32'd0);
            chk("commit.misalign", {31'd0, misalign}, 32'd0);
        end
    endtask

    task automatic run_inst(input int ad, input int dd, input logic [1:0] src,
                            input logic [31:0] imm_v, input logic [31:0] alu_v);
        fetch_phase(ad, $urandom);
        exec_phase(dd, src, imm_v, alu_v);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
        PcSrc = 2'b00; imm = 32'h0; alu_result = 32'h0;
        mpc = 32'h0; minst = 32'h0; mhalt = 1'b0;
        step();
        step();
        chk_reset_values("reset");

        // leave reset with a stray ack during BOOT
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("boot.inst", inst, 32'h0);
        chk("boot.valid", {31'd0, inst_valid}, 32'd0);

        fetch_phase(0, 32'h0050_0093);
        exec_phase(0, 2'b10, 32'h0, 32'h0000_0011);   // jalr -> 0x10
        run_inst(0, 0, 2'b00, 32'h0, 32'h0);          // 0x10 -> 0x14
        run_inst(0, 0, 2'b10, 32'h0, 32'hFFFF_FFFD);  // -> 0xFFFFFFFC
        run_inst(0, 0, 2'b00, 32'h0, 32'h0);          // wraps to 0
        run_inst(0, 0, 2'b10, 32'h0, 32'h0000_0020);  // -> 0x20
        run_inst(0, 0, 2'b01, 32'hFFFF_FFF8, 32'h0);  // branch back -> 0x18
        run_inst(0, 0, 2'b10, 32'h0, 32'h0000_0041);  // jalr -> 0x40
        run_inst(3, 4, 2'b11, 32'h0, 32'h0);          // stalls, replay 0x40

        // randomized aligned flow
        for (int n = 0; n < 25; n++) begin
            run_inst($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom),
                     $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD);
        end

        // reset while fetching
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_values("rst_fetch");
        step();
        fetch_phase(1, $urandom);
        // reset while executing
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_values("rst_exec");
        step();

        // misaligned branch target traps
        run_inst(0, 0, 2'b10, 32'h0, 32'h0000_0020);
        run_inst(1, 1, 2'b01, 32'h0000_0006, 32'h0);
        chk("mhalt", {31'd0, mhalt}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            imem_ack   = $urandom_range(0, 1);
            exec_done  = $urandom_range(0, 1);
            PcSrc      = 2'($urandom);
            imm        = $urandom;
            alu_result = $urandom;
            step();
            chk("halt.pc", pc, mpc);
            chk("halt.req", {31'd0, imem_req}, 32'd0);
            chk("halt.valid", {31'd0, inst_valid}, 32'd0);
            chk("halt.halted", {31'd0, halted}, 32'd1);
            chk("halt.misalign", {31'd0, misalign}, 32'd1);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_values("rst_halt");
        step();
        // misaligned jalr target (bit 1 set) also traps
        run_inst(0, 0, 2'b10, 32'h0, 32'h0000_0043);
        chk("jalr_trap", {31'd0, mhalt}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
